mul_sequencer: RTL and testbench
================================

# mul_sequencer

Multi-cycle unsigned multiplier controller that sequences the shared single-cycle ALU through a shift-add algorithm instead of adding a dedicated multiplier array. It accepts one operand pair per start pulse and issues one `ALU_ADD` per iteration on its ALU port group. It returns either the low or the high `DATA_WIDTH` bits of the full unsigned product (MUL / MULHU semantics). It sits beside the ALU in the execute stage and is started by the core control logic for M-extension multiply ops.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op_hi`  in  1  0 = return low half (MUL), 1 = return high half (MULHU); latched with `start`.
- `src_a`  in  DATA_WIDTH  multiplicand; latched with `start`.
- `src_b`  in  DATA_WIDTH  multiplier; latched with `start`.
- `busy`  out  1  high while iterating (RUN).
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  DATA_WIDTH  selected product half; held until the next accepted start completes.
- `alu_a`  out  DATA_WIDTH  to the shared ALU `a`.
- `alu_b`  out  DATA_WIDTH  to the shared ALU `b`.
- `alu_op`  out  alu_ops_e  to the shared ALU; always `ALU_ADD`.
- `alu_result`  in  DATA_WIDTH  from the shared ALU result.

## Operation
- Registers:
  - `mcand` (W bits), `acc_hi` (W), `acc_lo` (W).
  - `sel_hi` (1).
  - `count` ($clog2(W)+1 bits).
  - `result` (W), `state`.
- States: IDLE, RUN, DONE.
- IDLE, `start`=1:
  - Load `mcand`←`src_a`, `acc_hi`←0, `acc_lo`←`src_b`, `sel_hi`←`op_hi`, `count`←0.
  - Go to RUN.
- IDLE, `start`=0: stay in IDLE.
- RUN, each cycle:
  - Drive `alu_a`=`acc_hi` and `alu_b`=`acc_lo[0] ? mcand : 0`.
  - Compute `sum`=`alu_result`.
  - Compute carry `c`=(`sum` < `acc_hi`), unsigned compare.
  - Update `acc_hi`←{`c`, `sum[W-1:1]`} and `acc_lo`←{`sum[0]`, `acc_lo[W-1:1]`}.
  - Increment `count`.
- RUN exit: when `count`=W-1 on the current cycle, that is the last iteration. Latch `result`←(`sel_hi` ? new `acc_hi` : new `acc_lo`) and go to DONE.
- DONE:
  - `done`=1 for exactly this cycle.
  - `start`=1: behave as IDLE+start (back-to-back accept, next state RUN).
  - Otherwise go to IDLE.
- `start` during RUN is ignored; it is neither queued nor does it alter the operation.
- Outside RUN: `alu_a`=0, `alu_b`=0, `alu_op`=`ALU_ADD`. The ALU is combinational, so its zero flag is unused here.
- Product is a full unsigned 2W-bit product `src_a`×`src_b`; no signed variants.
- Zero operands take no early exit; latency is fixed.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, all accumulators 0, `alu_a`=`alu_b`=0.
- Latency:
  - `start` sampled at edge N.
  - RUN occupies cycles N+1 … N+W (W ALU adds).
  - `done`=1 and `result` valid in cycle N+W+1.
- Throughput: one multiply per W+1 cycles with back-to-back starts.
- `busy` is registered from state and is high in exactly W cycles per operation.
- ALU path is combinational within a cycle: `alu_a`/`alu_b` are driven from registers, and `alu_result` is consumed at the same edge.
- `rst` mid-RUN or in DONE:
  - At the next edge, return to IDLE and clear `busy`, `done` and `result`.
  - The in-flight operation is discarded; no `done` pulse for it.
- `rst` and `start` in the same cycle: reset wins and `start` is dropped.

## Test plan
- Basic MUL: `start`, `src_a`=3, `src_b`=5, `op_hi`=0. Require `done` exactly 33 cycles after the start edge, `result`=15, and `busy` high for exactly 32 cycles.
- High half:
  - `src_a`=`src_b`=0xFFFFFFFF with `op_hi`=1 gives `result`=0xFFFFFFFE.
  - Repeat with `op_hi`=0, which gives `result`=0x00000001.
  - This case exercises carry generation on every iteration.
- Start ignored while busy:
  - Start with 7×6, then pulse `start` with 2×2 at cycle +10.
  - Require a single `done` at +33 with `result`=42, and no second `done`.
- Back-to-back:
  - Assert `start` (0x10000×0x10000, `op_hi`=1) in the DONE cycle of a prior op.
  - Require the next `done` exactly 33 cycles later with `result`=0x00000001, and `busy` re-asserted the cycle after DONE.
- Reset mid-operation:
  - Start 9×9, then assert `rst` at cycle +12.
  - Require the next cycle to show `busy`=0, `result`=0, `alu_a`=`alu_b`=0, and no `done`.
  - A subsequent start with 9×9 yields 81.
- Zero operand: `src_a`=0, `src_b`=0xDEADBEEF for both `op_hi` values. Require `result`=0 with unchanged W+1 latency.

Source files
------------

// File: rtl/mul_sequencer.sv
// Shift-add unsigned multiplier controller that borrows the shared execute-stage ALU
// for one add per iteration; returns the low (MUL) or high (MULHU) product half.
package mul_sequencer_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_ops_e;
endpackage

module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_op_hi,
    input  logic [DATA_WIDTH-1:0] i_src_a,
    input  logic [DATA_WIDTH-1:0] i_src_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output alu_ops_e              o_alu_op,
    input  logic [DATA_WIDTH-1:0] i_alu_result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [W-1:0]    r_mcand;
    logic [W-1:0]    r_acc_hi;
    logic [W-1:0]    r_acc_lo;
    logic            r_sel_hi;
    logic [CW-1:0]   r_count;
    logic [W-1:0]    r_result;
    logic            r_busy;
    logic            r_done;

    logic            w_run;
    logic            w_accept;
    logic            w_last;
    logic            w_carry;
    logic [W-1:0]    w_acc_hi_nxt;
    logic [W-1:0]    w_acc_lo_nxt;

    assign w_run    = (r_state == S_RUN);
    assign w_accept = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_count == CW'(W - 1));

    // The ALU wraps at W bits; a wrapped sum is smaller than the addend it started from.
    assign w_carry      = (i_alu_result < r_acc_hi);
    assign w_acc_hi_nxt = {w_carry, i_alu_result[W-1:1]};
    assign w_acc_lo_nxt = {i_alu_result[0], r_acc_lo[W-1:1]};

    assign o_alu_a  = w_run ? r_acc_hi : '0;
    assign o_alu_b  = (w_run && r_acc_lo[0]) ? r_mcand : '0;
    assign o_alu_op = ALU_ADD;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = i_start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_sel_hi <= 1'b0;
            r_count  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_mcand  <= i_src_a;
            r_acc_hi <= '0;
            r_acc_lo <= i_src_b;
            r_sel_hi <= i_op_hi;
            r_count  <= '0;
        end else if (w_run) begin
            r_acc_hi <= w_acc_hi_nxt;
            r_acc_lo <= w_acc_lo_nxt;
            r_count  <= r_count + 1'b1;
            if (w_last)
                r_result <= r_sel_hi ? w_acc_hi_nxt : w_acc_lo_nxt;
        end
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: arithmetic product model checked every cycle, plus
// directed cases with hand-computed results, latency and busy-length expectations.
module tb_mul_sequencer;
    import mul_sequencer_pkg::*;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op_hi = 1'b0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         busy, done;
    logic [W-1:0] result, alu_a, alu_b, alu_result;
    alu_ops_e     alu_op;

    int n_pass  = 0;
    int n_total = 0;

    // Shared single-cycle ALU stand-in; the op is checked to be ADD every cycle.
    assign alu_result = alu_a + alu_b;

    always #5 clk = ~clk;

    mul_sequencer #(.DATA_WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op_hi(op_hi),
        .i_src_a(src_a), .i_src_b(src_b),
        .o_busy(busy), .o_done(done), .o_result(result),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .i_alu_result(alu_result)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: a job accepted when idle finishes W+1 edges later with the product half.
    logic         m_ok = 1'b0;
    logic         m_act = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_exp = '0;
    logic [W-1:0] m_a = '0;
    int           m_left = 0;

    always @(posedge clk) begin
        logic [2*W-1:0] p;
        logic           acc;
        m_ok = 1'b1;
        if (rst) begin
            m_act = 1'b0; m_done = 1'b0; m_res = '0; m_left = 0;
        end else begin
            acc    = !m_act && start;
            m_done = 1'b0;
            if (m_act) begin
                m_left--;
                if (m_left == 0) begin
                    m_act = 1'b0; m_done = 1'b1; m_res = m_exp;
                end
            end
            if (acc) begin
                p      = (2*W)'(src_a) * (2*W)'(src_b);
                m_exp  = op_hi ? p[2*W-1:W] : p[W-1:0];
                m_a    = src_a;
                m_act  = 1'b1;
                m_left = W;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("busy", 64'(busy), 64'(m_act));
            chk("done", 64'(done), 64'(m_done));
            chk("result", 64'(result), 64'(m_res));
            chk("alu_op", 64'(alu_op), 64'(ALU_ADD));
            if (!m_act) begin
                chk("alu_a_idle", 64'(alu_a), 64'd0);
                chk("alu_b_idle", 64'(alu_b), 64'd0);
            end else begin
                chk("alu_b_run", 64'(alu_b == '0 || alu_b == m_a), 64'd1);
            end
        end
    end

    // Called #1 after an edge. Returns result, latency in cycles (done cycle index
    // counting the start-sample edge as cycle 0's end), busy cycle count, busy just after start.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic hi,
                       input int inj, output logic [W-1:0] res, output int lat,
                       output int nbusy, output logic busy0);
        bit seen = 0;
        start = 1'b1; src_a = a; src_b = b; op_hi = hi;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; nbusy = 0; busy0 = busy; res = '0;
        for (int k = 0; k < 60; k++) begin
            if (busy) nbusy++;
            if (done) begin
                lat = k + 1; res = result; seen = 1;
                break;
            end
            start = (k == inj);
            if (k == inj) begin
                src_a = $urandom; src_b = $urandom; op_hi = $urandom_range(0, 1);
            end
            @(posedge clk); #1;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] res;
        int           lat, nb, nd;
        logic         b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(32'd3, 32'd5, 1'b0, -1, res, lat, nb, b0);
        chk("basic_res", 64'(res), 64'd15);
        chk("basic_lat", 64'(lat), 64'd33);
        chk("basic_busy", 64'(nb), 64'd32);

        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, res, lat, nb, b0);
        chk("maxhi_res", 64'(res), 64'hFFFF_FFFE);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, res, lat, nb, b0);
        chk("maxlo_res", 64'(res), 64'h1);

        run(32'd7, 32'd6, 1'b0, 9, res, lat, nb, b0);
        chk("ign_res", 64'(res), 64'd42);
        chk("ign_lat", 64'(lat), 64'd33);
        count_done(40, nd);
        chk("ign_no_second_done", 64'(nd), 64'd0);

        run(32'd11, 32'd13, 1'b0, -1, res, lat, nb, b0);
        chk("b2b_first_res", 64'(res), 64'd143);
        run(32'h1_0000, 32'h1_0000, 1'b1, -1, res, lat, nb, b0);
        chk("b2b_res", 64'(res), 64'h1);
        chk("b2b_lat", 64'(lat), 64'd33);
        chk("b2b_busy_next", 64'(b0), 64'd1);

        start = 1'b1; src_a = 32'd9; src_b = 32'd9; op_hi = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_result", 64'(result), 64'd0);
        chk("mrst_alu_a", 64'(alu_a), 64'd0);
        chk("mrst_alu_b", 64'(alu_b), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        count_done(40, nd);
        chk("mrst_no_done", 64'(nd), 64'd0);
        run(32'd9, 32'd9, 1'b0, -1, res, lat, nb, b0);
        chk("mrst_after_res", 64'(res), 64'd81);

        run(32'd0, 32'hDEAD_BEEF, 1'b0, -1, res, lat, nb, b0);
        chk("zero_lo_res", 64'(res), 64'd0);
        chk("zero_lo_lat", 64'(lat), 64'd33);
        run(32'd0, 32'hDEAD_BEEF, 1'b1, -1, res, lat, nb, b0);
        chk("zero_hi_res", 64'(res), 64'd0);
        chk("zero_hi_lat", 64'(lat), 64'd33);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            run(pick(), pick(), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1,
                res, lat, nb, b0);
            chk("rand_lat", 64'(lat), 64'd33);
            chk("rand_busy", 64'(nb), 64'd32);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
